phase_controller: RTL and testbench

- One-hot instruction phase sequencer for the CPU datapath. It drives the 8-bit phase vector PH1..PH8 that gates datapath operations.
- It owns the memory request handshake, counts multi-cycle execute steps and handles trap, halt, memory-timeout and illegal-encoding recovery.
- Sits between the decode logic (need_op, indirect, exec_len, wb_en), the memory port (mem_req/mem_ack) and the interrupt/console controls.

---
 rtl/phase_controller.sv | 211 +++++++++++++++++++++
 tb/tb_phase_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_controller.sv
// phase_controller: one-hot instruction phase sequencer for the CPU datapath.
// Drives PH1..PH8 (phase[7]..phase[0]), owns the memory request handshake,
// counts execute cycles and recovers from traps, halts, memory timeouts and
// corrupted (non-one-hot) state.
module phase_controller #(
    parameter int EXEC_W      = 4,
    parameter int COUNT_W     = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               run,
    input  logic               halt_req,
    input  logic               irq,
    input  logic               mem_ack,
    input  logic               need_op,
    input  logic               indirect,
    input  logic [EXEC_W-1:0]  exec_len,
    input  logic               wb_en,
    output logic [7:0]         phase,
    output logic               mem_req,
    output logic               busy,
    output logic               trap,
    output logic               mem_fault,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    // Wait counter only has to reach MEM_TIMEOUT-1 before the phase is abandoned.
    localparam int WAIT_W = $clog2(MEM_TIMEOUT);

    typedef enum logic [7:0] {
        PH1 = 8'h80,  // fetch
        PH2 = 8'h40,  // decode
        PH3 = 8'h20,  // operand
        PH4 = 8'h10,  // indirect
        PH5 = 8'h08,  // execute
        PH6 = 8'h04,  // writeback
        PH7 = 8'h02,  // trap
        PH8 = 8'h01   // halt
    } phase_e;

    // True when exactly one bit of the phase vector is set.
    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

    // The state register is plain logic rather than phase_e so that it can
    // hold (and we can detect) a corrupted, non-one-hot value.
    logic [7:0]         state_r;
    phase_e             next_s;
    phase_e             boundary_next_s;
    logic [EXEC_W-1:0]  exec_cnt_r;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [COUNT_W-1:0] count_r;
    logic               mem_fault_r;
    logic               illegal_r;
    logic               wait_hit_s;
    logic               mem_phase_s;
    logic               boundary_s;
    logic               timeout_s;
    logic               set_illegal_s;
    logic               clear_flags_s;

    assign wait_hit_s  = (wait_cnt_r == WAIT_W'(MEM_TIMEOUT - 1));
    assign mem_phase_s = state_r[7] | state_r[5] | state_r[4];

    // Next-state and event decode; boundary target is resolved by priority halt > irq > fetch.
    always_comb begin
        next_s          = PH8;
        boundary_s      = 1'b0;
        timeout_s       = 1'b0;
        set_illegal_s   = 1'b0;
        clear_flags_s   = 1'b0;
        boundary_next_s = halt_req ? PH8 : (irq ? PH7 : PH1);
        case (state_r)
            PH8: begin
                if (run) begin
                    next_s        = PH1;
                    clear_flags_s = 1'b1;
                end else begin
                    next_s = PH8;
                end
            end
            PH1: begin
                if (mem_ack) begin
                    next_s = PH2;
                end else if (wait_hit_s) begin
                    next_s    = PH7;
                    timeout_s = 1'b1;
                end else begin
                    next_s = PH1;
                end
            end
            PH2: begin
                next_s = need_op ? PH3 : PH5;
            end
            PH3: begin
                if (mem_ack) begin
                    next_s = indirect ? PH4 : PH5;
                end else if (wait_hit_s) begin
                    next_s    = PH7;
                    timeout_s = 1'b1;
                end else begin
                    next_s = PH3;
                end
            end
            PH4: begin
                if (mem_ack) begin
                    next_s = PH5;
                end else if (wait_hit_s) begin
                    next_s    = PH7;
                    timeout_s = 1'b1;
                end else begin
                    next_s = PH4;
                end
            end
            PH5: begin
                if (exec_cnt_r == '0) begin
                    if (wb_en) begin
                        next_s = PH6;
                    end else begin
                        next_s     = boundary_next_s;
                        boundary_s = 1'b1;
                    end
                end else begin
                    next_s = PH5;
                end
            end
            PH6: begin
                next_s     = boundary_next_s;
                boundary_s = 1'b1;
            end
            PH7: begin
                next_s = halt_req ? PH8 : PH1;
            end
            default: begin
                next_s        = PH8;
                set_illegal_s = 1'b1;
            end
        endcase
    end

    // Phase register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= PH8;
        end else begin
            state_r <= next_s;
        end
    end

    // Execute counter: loaded in decode, counts down to zero through execute.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exec_cnt_r <= '0;
        end else if (state_r == PH2) begin
            exec_cnt_r <= exec_len;
        end else if ((state_r == PH5) && (exec_cnt_r != '0)) begin
            exec_cnt_r <= exec_cnt_r - EXEC_W'(1);
        end else begin
            exec_cnt_r <= exec_cnt_r;
        end
    end

    // Memory wait counter: runs only while a memory phase is held waiting, zero on any phase change.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_r <= '0;
        end else if (mem_phase_s && !mem_ack && (next_s == state_r)) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= '0;
        end
    end

    // Sticky fault flags, cleared only when leaving HALT on run.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_fault_r <= 1'b0;
            illegal_r   <= 1'b0;
        end else if (clear_flags_s) begin
            mem_fault_r <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            mem_fault_r <= mem_fault_r | timeout_s;
            illegal_r   <= illegal_r | set_illegal_s;
        end
    end

    // Retired-instruction counter, bumped on every instruction boundary.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= '0;
        end else if (boundary_s) begin
            count_r <= count_r + COUNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // All outputs decode straight from registers, so they carry no glitches.
    assign phase       = state_r;
    assign mem_req     = mem_phase_s;
    assign busy        = (state_r != PH8);
    assign trap        = (state_r == PH7);
    assign mem_fault   = mem_fault_r;
    assign illegal     = illegal_r;
    assign instr_count = count_r;

endmodule

// File: tb/tb_phase_controller.sv
// Directed bench for phase_controller: a per-cycle vector table for the
// short-instruction, trap and halt paths, plus hand-written sequences for the
// long instruction, memory timeout, illegal state and asynchronous reset.
module tb_phase_controller;

    logic        clock;
    logic        reset_n;
    logic        run;
    logic        halt_req;
    logic        irq;
    logic        mem_ack;
    logic        need_op;
    logic        indirect;
    logic [3:0]  exec_len;
    logic        wb_en;
    logic [7:0]  phase;
    logic        mem_req;
    logic        busy;
    logic        trap;
    logic        mem_fault;
    logic        illegal;
    logic [15:0] instr_count;

    int tests = 0;
    int fails = 0;

    // Memory responder state: per-phase ack delay in cycles.
    int         d1 = 0;
    int         d3 = 0;
    int         d4 = 0;
    int         age = 0;
    logic [7:0] prev_ph = 8'h01;

    phase_controller #(.EXEC_W(4), .COUNT_W(16), .MEM_TIMEOUT(64)) dut (
        .clock(clock), .reset_n(reset_n), .run(run), .halt_req(halt_req),
        .irq(irq), .mem_ack(mem_ack), .need_op(need_op), .indirect(indirect),
        .exec_len(exec_len), .wb_en(wb_en), .phase(phase), .mem_req(mem_req),
        .busy(busy), .trap(trap), .mem_fault(mem_fault), .illegal(illegal),
        .instr_count(instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        run;
        logic        halt_req;
        logic        irq;
        logic        need_op;
        logic        wb_en;
        logic [3:0]  exec_len;
        logic [7:0]  ph;
        logic        mreq;
        logic        busy;
        logic        trap;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic r, input logic h, input logic i,
                                input logic n, input logic w, input logic [3:0] e,
                                input logic [7:0] p, input logic m, input logic b,
                                input logic t, input logic [15:0] c);
        vec_t v;
        v.run = r; v.halt_req = h; v.irq = i; v.need_op = n; v.wb_en = w;
        v.exec_len = e; v.ph = p; v.mreq = m; v.busy = b; v.trap = t; v.cnt = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic update_ack();
        mem_ack = ((phase == 8'h80) && (age >= d1)) ||
                  ((phase == 8'h20) && (age >= d3)) ||
                  ((phase == 8'h10) && (age >= d4));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (phase != prev_ph) age = 0;
        else age++;
        prev_ph = phase;
        update_ack();
    endtask

    logic [7:0] long_exp[15];

    initial begin
        reset_n = 1'b0; run = 1'b0; halt_req = 1'b0; irq = 1'b0; mem_ack = 1'b0;
        need_op = 1'b0; indirect = 1'b0; exec_len = 4'd0; wb_en = 1'b0;

        //              run h  i  n  w  len    phase  mr b  t  count
        vecs[0]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,4'd0, 8'h80,1'b1,1'b1,1'b0,16'd0);
        vecs[1]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 8'h40,1'b0,1'b1,1'b0,16'd0);
        vecs[2]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 8'h08,1'b0,1'b1,1'b0,16'd0);
        vecs[3]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 8'h80,1'b1,1'b1,1'b0,16'd1);
        vecs[4]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 8'h40,1'b0,1'b1,1'b0,16'd1);
        vecs[5]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 8'h08,1'b0,1'b1,1'b0,16'd1);
        vecs[6]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 8'h80,1'b1,1'b1,1'b0,16'd2);
        vecs[7]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,4'd0, 8'h40,1'b0,1'b1,1'b0,16'd2);
        vecs[8]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,4'd0, 8'h08,1'b0,1'b1,1'b0,16'd2);
        vecs[9]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,4'd0, 8'h02,1'b0,1'b1,1'b1,16'd3);
        vecs[10] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 8'h80,1'b1,1'b1,1'b0,16'd3);
        vecs[11] = mk(1'b0,1'b1,1'b0,1'b0,1'b0,4'd0, 8'h40,1'b0,1'b1,1'b0,16'd3);
        vecs[12] = mk(1'b0,1'b1,1'b0,1'b0,1'b0,4'd0, 8'h08,1'b0,1'b1,1'b0,16'd3);
        vecs[13] = mk(1'b0,1'b1,1'b1,1'b0,1'b0,4'd0, 8'h01,1'b0,1'b0,1'b0,16'd4);
        vecs[14] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 8'h01,1'b0,1'b0,1'b0,16'd4);
        vecs[15] = mk(1'b1,1'b0,1'b0,1'b0,1'b0,4'd0, 8'h80,1'b1,1'b1,1'b0,16'd4);
        vecs[16] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 8'h40,1'b0,1'b1,1'b0,16'd4);
        vecs[17] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,4'd2, 8'h08,1'b0,1'b1,1'b0,16'd4);
        vecs[18] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 8'h08,1'b0,1'b1,1'b0,16'd4);
        vecs[19] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 8'h08,1'b0,1'b1,1'b0,16'd4);
        vecs[20] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,4'd0, 8'h04,1'b0,1'b1,1'b0,16'd4);
        vecs[21] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 8'h80,1'b1,1'b1,1'b0,16'd5);

        long_exp = '{8'h80, 8'h80, 8'h40, 8'h20, 8'h20, 8'h20, 8'h10, 8'h10,
                     8'h10, 8'h08, 8'h08, 8'h08, 8'h08, 8'h04, 8'h80};

        // Reset state
        tick();
        tick();
        check("reset", 64'({phase, mem_req, busy, trap, mem_fault, illegal, instr_count}),
              64'({8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}));
        reset_n = 1'b1;

        // Per-cycle vector table
        for (int i = 0; i < 22; i++) begin
            run = vecs[i].run; halt_req = vecs[i].halt_req; irq = vecs[i].irq;
            need_op = vecs[i].need_op; wb_en = vecs[i].wb_en; exec_len = vecs[i].exec_len;
            tick();
            check($sformatf("vec%0d", i),
                  64'({phase, mem_req, busy, trap, instr_count}),
                  64'({vecs[i].ph, vecs[i].mreq, vecs[i].busy, vecs[i].trap, vecs[i].cnt}));
        end
        run = 1'b0; wb_en = 1'b0; exec_len = 4'd0;

        // Long instruction: 2-cycle ack delays, indirect operand, 4 execute cycles, writeback
        d1 = 2; d3 = 2; d4 = 2;
        need_op = 1'b1; indirect = 1'b1; exec_len = 4'd3; wb_en = 1'b1;
        update_ack();
        for (int k = 0; k < 15; k++) begin
            tick();
            check($sformatf("long%0d", k), 64'(phase), 64'(long_exp[k]));
        end
        check("long_count", 64'(instr_count), 64'(16'd6));

        // Operand timeout: no ack for 64 cycles in PH3
        d1 = 0; d3 = 1000; d4 = 0;
        need_op = 1'b1; indirect = 1'b0; exec_len = 4'd0; wb_en = 1'b0;
        update_ack();
        tick();
        tick();
        check("to_enter", 64'(phase), 64'(8'h20));
        for (int k = 0; k < 63; k++) tick();
        check("to_wait63", 64'({phase, mem_fault}), 64'({8'h20, 1'b0}));
        tick();
        check("to_trap", 64'({phase, trap, mem_fault, instr_count}),
              64'({8'h02, 1'b1, 1'b1, 16'd6}));
        tick();
        check("to_fetch", 64'({phase, mem_fault}), 64'({8'h80, 1'b1}));
        need_op = 1'b0; d3 = 0;
        tick(); tick(); tick();
        check("to_sticky", 64'({phase, mem_fault, instr_count}), 64'({8'h80, 1'b1, 16'd7}));
        halt_req = 1'b1;
        tick(); tick(); tick();
        check("to_halt", 64'({phase, busy, mem_fault, instr_count}),
              64'({8'h01, 1'b0, 1'b1, 16'd8}));
        halt_req = 1'b0; run = 1'b1;
        tick();
        check("to_clear", 64'({phase, mem_fault}), 64'({8'h80, 1'b0}));
        run = 1'b0;

        // Ack arriving on the 64th PH3 cycle still advances normally
        need_op = 1'b1; d3 = 63;
        update_ack();
        tick(); tick();
        for (int k = 0; k < 63; k++) tick();
        check("late_wait", 64'(phase), 64'(8'h20));
        tick();
        check("late_adv", 64'({phase, mem_fault}), 64'({8'h08, 1'b0}));
        tick();
        check("late_done", 64'({phase, instr_count}), 64'({8'h80, 16'd9}));
        d3 = 0; need_op = 1'b0;

        // Corrupted phase vector from HALT
        halt_req = 1'b1;
        update_ack();
        tick(); tick(); tick();
        check("ill_halt", 64'({phase, instr_count}), 64'({8'h01, 16'd10}));
        halt_req = 1'b0;
        force dut.state_r = 8'h18;
        tick();
        check("ill_flag", 64'(illegal), 64'(1'b1));
        release dut.state_r;
        tick();
        check("ill_ph8", 64'({phase, illegal}), 64'({8'h01, 1'b1}));
        tick();
        check("ill_stay", 64'({phase, illegal}), 64'({8'h01, 1'b1}));
        run = 1'b1;
        tick();
        check("ill_clear", 64'({phase, illegal}), 64'({8'h80, 1'b0}));
        run = 1'b0;

        // Asynchronous reset in the middle of execute
        exec_len = 4'd5;
        tick(); tick(); tick();
        check("rst_pre", 64'(phase), 64'(8'h08));
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async", 64'({phase, mem_req, busy, instr_count}),
              64'({8'h01, 1'b0, 1'b0, 16'd0}));
        reset_n = 1'b1;
        exec_len = 4'd0;
        tick();
        check("rst_after", 64'({phase, mem_req}), 64'({8'h01, 1'b0}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
